// File: rtl/ysyx_25040111_bus_pkg.sv
// Shared types and constants for the cache refill burst responder.
package ysyx_25040111_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_e;

    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [31:0] WORD_INC  = 32'd4;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } req_t;

    // Requests are always word-aligned; the low address bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_25040111_req_slot.sv
// One-deep holding register for a refill request that arrives while a burst is running.
module ysyx_25040111_req_slot
    import ysyx_25040111_bus_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic wr,
    input  logic clr,
    input  req_t wr_req,
    output req_t rd_req,
    output logic full,
    output logic full_next,
    output logic drop
);

    req_t req_r;
    logic full_r;
    logic drop_r;
    logic accept_s;
    logic reject_s;

    // A draining slot counts as free, so a write in the same cycle is kept.
    always_comb begin
        accept_s = 1'b0;
        reject_s = 1'b0;
        if (wr) begin
            if (!full_r || clr) begin
                accept_s = 1'b1;
            end else begin
                reject_s = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
        end
    end

    // Slot contents, occupancy and the registered drop pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_r  <= '0;
            full_r <= 1'b0;
            drop_r <= 1'b0;
        end else begin
            drop_r <= reject_s;
            if (accept_s) begin
                req_r  <= wr_req;
                full_r <= 1'b1;
            end else if (clr) begin
                full_r <= 1'b0;
            end else begin
                full_r <= full_r;
            end
        end
    end

    assign rd_req    = req_r;
    assign full      = full_r;
    assign full_next = accept_s | (full_r & ~clr);
    assign drop      = drop_r;

endmodule

// File: rtl/ysyx_25040111_burst_responder.sv
// Turns a cache refill request into rlen+1 single-beat AR/R reads and returns each word as a rok pulse.
module ysyx_25040111_burst_responder
    import ysyx_25040111_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rstart,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [LEN_W-1:0]  rlen,
    output logic              rok,
    output logic [DATA_W-1:0] rdata,
    output logic              rerr,
    output logic              rdrop,
    output logic              busy,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp
);

    state_e            state_r;
    state_e            next_state_s;
    logic [ADDR_W-1:0] cur_addr_r;
    logic [ADDR_W-1:0] cur_addr_nxt_s;
    logic [LEN_W-1:0]  cur_len_r;
    logic [LEN_W-1:0]  cur_len_nxt_s;
    logic [LEN_W-1:0]  beat_cnt_r;
    logic [LEN_W-1:0]  beat_cnt_nxt_s;
    logic              r_hs_s;

    logic              slot_wr_s;
    logic              slot_clr_s;
    logic              slot_full_s;
    logic              slot_full_nxt_s;
    logic              slot_drop_s;
    req_t              slot_in_s;
    req_t              slot_out_s;

    logic              rok_r;
    logic [DATA_W-1:0] rdata_r;
    logic              rerr_r;
    logic              busy_r;
    logic [ADDR_W-1:0] m_araddr_r;
    logic              m_arvalid_r;
    logic              m_rready_r;

    assign slot_in_s = '{addr: word_align(raddr), len: rlen};

    ysyx_25040111_req_slot u_slot (
        .clock     (clock),
        .reset     (reset),
        .wr        (slot_wr_s),
        .clr       (slot_clr_s),
        .wr_req    (slot_in_s),
        .rd_req    (slot_out_s),
        .full      (slot_full_s),
        .full_next (slot_full_nxt_s),
        .drop      (slot_drop_s)
    );

    // Next-state, burst bookkeeping and slot control.
    always_comb begin
        next_state_s   = state_r;
        cur_addr_nxt_s = cur_addr_r;
        cur_len_nxt_s  = cur_len_r;
        beat_cnt_nxt_s = beat_cnt_r;
        slot_wr_s      = 1'b0;
        slot_clr_s     = 1'b0;
        r_hs_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (slot_full_s) begin
                    cur_addr_nxt_s = slot_out_s.addr;
                    cur_len_nxt_s  = slot_out_s.len;
                    beat_cnt_nxt_s = {LEN_W{1'b0}};
                    slot_clr_s     = 1'b1;
                    slot_wr_s      = rstart;
                    next_state_s   = ST_AR;
                end else if (rstart) begin
                    cur_addr_nxt_s = word_align(raddr);
                    cur_len_nxt_s  = rlen;
                    beat_cnt_nxt_s = {LEN_W{1'b0}};
                    next_state_s   = ST_AR;
                end else begin
                    next_state_s   = ST_IDLE;
                end
            end
            ST_AR: begin
                slot_wr_s = rstart;
                if (m_arvalid_r && m_arready) begin
                    next_state_s = ST_R;
                end else begin
                    next_state_s = ST_AR;
                end
            end
            ST_R: begin
                slot_wr_s = rstart;
                if (m_rvalid && m_rready_r) begin
                    r_hs_s = 1'b1;
                    // Compare before incrementing so rlen=255 never wraps the counter.
                    if (beat_cnt_r == cur_len_r) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        cur_addr_nxt_s = cur_addr_r + WORD_INC;
                        beat_cnt_nxt_s = beat_cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
                        next_state_s   = ST_AR;
                    end
                end else begin
                    next_state_s = ST_R;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and burst context registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cur_addr_r <= {ADDR_W{1'b0}};
            cur_len_r  <= {LEN_W{1'b0}};
            beat_cnt_r <= {LEN_W{1'b0}};
        end else begin
            state_r    <= next_state_s;
            cur_addr_r <= cur_addr_nxt_s;
            cur_len_r  <= cur_len_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
        end
    end

    // Registered outputs, derived from the upcoming state so they line up with it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rok_r       <= 1'b0;
            rdata_r     <= {DATA_W{1'b0}};
            rerr_r      <= 1'b0;
            busy_r      <= 1'b0;
            m_araddr_r  <= {ADDR_W{1'b0}};
            m_arvalid_r <= 1'b0;
            m_rready_r  <= 1'b0;
        end else begin
            rok_r       <= r_hs_s;
            rerr_r      <= r_hs_s & (m_rresp != RESP_OKAY);
            busy_r      <= (next_state_s != ST_IDLE) | slot_full_nxt_s;
            m_arvalid_r <= (next_state_s == ST_AR);
            m_rready_r  <= (next_state_s == ST_R);
            if (r_hs_s) begin
                rdata_r <= m_rdata;
            end else begin
                rdata_r <= rdata_r;
            end
            if (next_state_s == ST_AR) begin
                m_araddr_r <= cur_addr_nxt_s;
            end else begin
                m_araddr_r <= m_araddr_r;
            end
        end
    end

    assign rok       = rok_r;
    assign rdata     = rdata_r;
    assign rerr      = rerr_r;
    assign rdrop     = slot_drop_s;
    assign busy      = busy_r;
    assign m_araddr  = m_araddr_r;
    assign m_arvalid = m_arvalid_r;
    assign m_rready  = m_rready_r;

endmodule

// File: tb/tb_ysyx_25040111_burst_responder.sv
// Self-checking bench: random-stall memory model plus a queue-based scoreboard of expected beats.
module tb_ysyx_25040111_burst_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rstart = 1'b0;
    logic [31:0] raddr = 32'd0;
    logic [7:0]  rlen = 8'd0;
    logic        rok;
    logic [31:0] rdata;
    logic        rerr;
    logic        rdrop;
    logic        busy;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic [31:0] m_rdata = 32'd0;
    logic [1:0]  m_rresp = 2'b00;

    int n_checks = 0;
    int n_errors = 0;
    int rok_cnt = 0;
    int rerr_cnt = 0;
    int unsigned max_stall = 0;
    logic [31:0] err_addr = 32'h0000_0001;

    logic [31:0] exp_addr_q[$];
    logic [32:0] exp_beat_q[$];
    logic [31:0] ar_q[$];
    logic        ar_wait = 1'b0;
    logic [31:0] ar_wait_addr = 32'd0;
    logic        r_hs_seen = 1'b0;
    logic        prev_rok = 1'b0;

    ysyx_25040111_burst_responder dut (
        .clock     (clock),
        .reset     (reset),
        .rstart    (rstart),
        .raddr     (raddr),
        .rlen      (rlen),
        .rok       (rok),
        .rdata     (rdata),
        .rerr      (rerr),
        .rdrop     (rdrop),
        .busy      (busy),
        .m_araddr  (m_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5EAD_BEFF;
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: a request is just a list of word addresses and the words they hold.
    task automatic push_req(input logic [31:0] addr, input int len);
        logic [31:0] a;
        for (int i = 0; i <= len; i++) begin
            a = {addr[31:2], 2'b00} + 32'(4 * i);
            exp_addr_q.push_back(a);
            exp_beat_q.push_back({(a == err_addr), mem_word(a)});
        end
    endtask

    task automatic send(input logic [31:0] addr, input logic [7:0] len);
        @(negedge clock);
        rstart = 1'b1;
        raddr  = addr;
        rlen   = len;
        @(negedge clock);
        rstart = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int start, input int nbeats);
        int cyc = 0;
        while ((busy || exp_beat_q.size() != 0) && cyc < 20000) begin
            @(negedge clock);
            cyc++;
        end
        repeat (3) @(negedge clock);
        check({tag, "_timeout"}, 64'(cyc < 20000), 64'd1);
        check({tag, "_beats"}, 64'(rok_cnt - start), 64'(nbeats));
        check({tag, "_ar_left"}, 64'(exp_addr_q.size()), 64'd0);
    endtask

    // Address channel observer: records handshakes and checks hold-stability during stalls.
    always @(posedge clock) begin
        r_hs_seen = 1'b0;
        if (!reset) begin
            ar_q.delete();
            ar_wait = 1'b0;
        end else begin
            if (ar_wait) begin
                check("ar_hold_valid", 64'(m_arvalid), 64'd1);
                check("ar_hold_addr", 64'(m_araddr), 64'(ar_wait_addr));
            end
            if (m_rvalid && m_rready) begin
                r_hs_seen = 1'b1;
                if (ar_q.size() > 0) void'(ar_q.pop_front());
            end
            if (m_arvalid && m_arready) begin
                if (exp_addr_q.size() == 0) check("ar_extra", 64'd1, 64'd0);
                else check("araddr", 64'(m_araddr), 64'(exp_addr_q.pop_front()));
                ar_q.push_back(m_araddr);
            end
            ar_wait      = m_arvalid && !m_arready;
            ar_wait_addr = m_araddr;
        end
    end

    // Memory driver and returned-word scoreboard.
    always @(negedge clock) begin
        if (!reset) begin
            m_arready = 1'b0;
            m_rvalid  = 1'b0;
            prev_rok  = 1'b0;
        end else begin
            if (rok) begin
                rok_cnt++;
                if (rerr) rerr_cnt++;
                check("rok_gap", 64'(prev_rok), 64'd0);
                if (exp_beat_q.size() == 0) begin
                    check("rok_extra", 64'd1, 64'd0);
                end else begin
                    logic [32:0] e;
                    e = exp_beat_q.pop_front();
                    check("rdata", 64'(rdata), 64'(e[31:0]));
                    check("rerr", 64'(rerr), 64'(e[32]));
                end
            end
            prev_rok  = rok;
            m_arready = ($urandom_range(0, max_stall) == 0);
            if (r_hs_seen) m_rvalid = 1'b0;
            if (!m_rvalid && ar_q.size() > 0 && $urandom_range(0, max_stall) == 0) begin
                m_rvalid = 1'b1;
                m_rdata  = mem_word(ar_q[0]);
                m_rresp  = (ar_q[0] == err_addr) ? 2'b10 : 2'b00;
            end
        end
    end

    initial begin
        int s;
        int seen;
        logic [31:0] a;
        int len;

        repeat (3) @(negedge clock);
        check("rst_rok", 64'(rok), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_arvalid", 64'(m_arvalid), 64'd0);
        check("rst_rready", 64'(m_rready), 64'd0);
        check("rst_araddr", 64'(m_araddr), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_rdrop", 64'(rdrop), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Single beat, zero wait states, exact latency.
        max_stall = 0;
        s = rok_cnt;
        push_req(32'h8000_0010, 0);
        rstart = 1'b1;
        raddr  = 32'h8000_0010;
        rlen   = 8'd0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            rstart = 1'b0;
            check("t1_rok_timing", 64'(rok), 64'(k == 3));
            if (k == 3) begin
                check("t1_rdata", 64'(rdata), 64'h0000_0000_DEAD_BEEF);
                check("t1_rerr", 64'(rerr), 64'd0);
            end
            if (k == 4) check("t1_busy", 64'(busy), 64'd0);
        end
        wait_done("t1", s, 1);

        // Unaligned 4-beat burst with random stalls.
        max_stall = 3;
        s = rok_cnt;
        push_req(32'h8000_0103, 3);
        send(32'h8000_0103, 8'd3);
        wait_done("t2", s, 4);

        // Error on the second beat only.
        err_addr = 32'h9000_0004;
        s = rok_cnt;
        seen = rerr_cnt;
        push_req(32'h9000_0000, 2);
        send(32'h9000_0000, 8'd2);
        wait_done("t3", s, 3);
        check("t3_err_count", 64'(rerr_cnt - seen), 64'd1);
        err_addr = 32'h0000_0001;

        // Address wrap with the maximum burst length.
        max_stall = 1;
        s = rok_cnt;
        push_req(32'hFFFF_FFF8, 255);
        send(32'hFFFF_FFF8, 8'd255);
        wait_done("t4", s, 256);

        // A runs, B is buffered, C is dropped.
        max_stall = 0;
        s = rok_cnt;
        push_req(32'h0000_4000, 3);
        push_req(32'h0000_5000, 1);
        send(32'h0000_4000, 8'd3);
        @(negedge clock);
        rstart = 1'b1;
        raddr  = 32'h0000_5000;
        rlen   = 8'd1;
        @(negedge clock);
        check("t5_no_drop_b", 64'(rdrop), 64'd0);
        raddr  = 32'h0000_6000;
        rlen   = 8'd2;
        @(negedge clock);
        rstart = 1'b0;
        check("t5_drop_c", 64'(rdrop), 64'd1);
        @(negedge clock);
        check("t5_drop_pulse", 64'(rdrop), 64'd0);
        wait_done("t5", s, 6);

        // Randomized single requests with random stalls and error placement.
        for (int it = 0; it < 8; it++) begin
            a         = $urandom;
            len       = int'($urandom_range(0, 7));
            max_stall = $urandom_range(0, 3);
            err_addr  = {a[31:2], 2'b00} + 32'(4 * $urandom_range(0, len));
            s = rok_cnt;
            push_req(a, len);
            send(a, 8'(len));
            wait_done("rand", s, len + 1);
        end
        err_addr = 32'h0000_0001;

        // Asynchronous reset in the middle of a burst.
        max_stall = 0;
        push_req(32'h0000_1000, 7);
        send(32'h0000_1000, 8'd7);
        seen = 0;
        for (int c = 0; c < 200 && seen < 2; c++) begin
            @(negedge clock);
            if (rok) seen++;
        end
        check("t6_reached", 64'(seen), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rok", 64'(rok), 64'd0);
        check("t6_arvalid", 64'(m_arvalid), 64'd0);
        check("t6_rready", 64'(m_rready), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        exp_addr_q.delete();
        exp_beat_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        s = rok_cnt;
        push_req(32'h0000_2000, 1);
        send(32'h0000_2000, 8'd1);
        wait_done("t6_after", s, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
